// File: rtl/pegasus_pkt_pkg.sv
// Shared definitions for the packet arbiter slice: FSM state encoding,
// statistics counter width and saturating counter arithmetic.
package pegasus_pkt_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Add inc to cnt, clamping at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Saturating increment by one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return sat_add(cnt, CNT_W'(1));
  endfunction

endpackage

// File: rtl/pkt_rr_pick.sv
// Combinational rotate-priority picker.
// Ports:
//   req   in   NUM_SRC  request vector
//   last  in   SRC_W    most recently granted source; search starts at last+1
//   gnt   out  SRC_W    first requester at or after last+1 (mod NUM_SRC)
//   any   out  1        at least one request present
module pkt_rr_pick #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic [SRC_W-1:0]   gnt,
  output logic               any
);

  int unsigned idx;

  // Walk the ring starting just after last; the first hit wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(last) + k) % NUM_SRC;
      if (!any && req[SRC_W'(idx)]) begin
        any = 1'b1;
        gnt = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-atomic round-robin arbiter: merges NUM_SRC valid/sop/eop streams into
// one tagged stream, granting whole packets and aborting packets whose source
// stalls mid-packet for TMO_CYC cycles.
// Ports:
//   clk, rst                         clock, async active-high reset
//   src_valid/sop/eop/error [N]      per-source beat qualifiers
//   src_data [N*WIDTH]               source i at [i*WIDTH +: WIDTH]
//   src_ready [N]                    per-source accept
//   out_valid/sop/eop/error/data     merged stream
//   out_src_id [SRC_W]               owner of the current packet
//   out_ready                        downstream ready
//   orphan_cnt, abort_cnt [8]        saturating statistics
module pkt_rr_arb
  import pegasus_pkt_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned TMO_CYC = 256,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC-1:0]       src_sop,
  input  logic [NUM_SRC-1:0]       src_eop,
  input  logic [NUM_SRC-1:0]       src_error,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_error,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src_id,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         orphan_cnt,
  output logic [CNT_W-1:0]         abort_cnt
);

  localparam int unsigned      TMO_W    = $clog2(TMO_CYC) + 1;
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_SRC - 1);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] orphan_q, orphan_d;
  logic [CNT_W-1:0] abort_q, abort_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] orphan;
  logic [CNT_W-1:0]   orphan_pc;
  logic [SRC_W-1:0]   pick_gnt;
  logic               pick_any;
  logic [WIDTH-1:0]   data_arr [NUM_SRC];

  assign req    = src_valid & src_sop;
  assign orphan = src_valid & ~src_sop;

  // Unpack the flat data bus so the granted beat is a plain array index.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_data
    assign data_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Number of orphan beats discarded this cycle.
  always_comb begin
    orphan_pc = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      orphan_pc = orphan_pc + CNT_W'(orphan[i]);
    end
  end

  pkt_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      last_q   <= LAST_RST;
      tmo_q    <= '0;
      orphan_q <= '0;
      abort_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      orphan_q <= orphan_d;
      abort_q  <= abort_d;
    end
  end

  assign orphan_cnt = orphan_q;
  assign abort_cnt  = abort_q;

  // Next state and stream muxing.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    orphan_d   = orphan_q;
    abort_d    = abort_q;
    src_ready  = '0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_error  = 1'b0;
    out_data   = '0;
    out_src_id = '0;

    case (state_q)
      ST_IDLE: begin
        // Non-sop beats outside a packet are swallowed; sop beats wait for a grant.
        src_ready = orphan;
        orphan_d  = sat_add(orphan_q, orphan_pc);
        tmo_d     = '0;
        if (pick_any) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        out_valid          = src_valid[gnt_q];
        out_sop            = src_sop[gnt_q];
        out_eop            = src_eop[gnt_q];
        out_error          = src_error[gnt_q];
        out_data           = data_arr[gnt_q];
        out_src_id         = gnt_q;
        src_ready[gnt_q]   = out_ready;
        // Only source-side starvation counts toward the timeout.
        if (src_valid[gnt_q]) begin
          tmo_d = '0;
          if (out_ready && src_eop[gnt_q]) begin
            state_d = ST_IDLE;
          end
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          tmo_d   = '0;
          state_d = ST_ABORT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_ABORT: begin
        // Synthetic terminating beat so downstream can drop the packet.
        out_valid  = 1'b1;
        out_eop    = 1'b1;
        out_error  = 1'b1;
        out_src_id = gnt_q;
        if (out_ready) begin
          abort_d = sat_inc(abort_q);
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Self-checking bench for pkt_rr_arb: a reset-time vector table for the
// IDLE grant/discard rules, then scoreboarded packet sequences.
module tb_pkt_rr_arb;

  localparam int unsigned NS  = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] src_valid, src_sop, src_eop, src_error, src_ready;
  logic [NS*W-1:0] src_data;
  logic          out_valid, out_sop, out_eop, out_error, out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src_id;
  logic [7:0]    orphan_cnt, abort_cnt;

  always #5 clk = ~clk;

  pkt_rr_arb #(.NUM_SRC(NS), .WIDTH(W), .TMO_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_error  (src_error),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_error  (out_error),
    .out_data   (out_data),
    .out_src_id (out_src_id),
    .out_ready  (out_ready),
    .orphan_cnt (orphan_cnt),
    .abort_cnt  (abort_cnt)
  );

  typedef struct packed {
    logic         v;
    logic         sop;
    logic         eop;
    logic         err;
    logic [W-1:0] data;
  } sbeat_t;

  typedef struct {
    logic         sop;
    logic         eop;
    logic         err;
    logic [1:0]   id;
    logic [W-1:0] data;
    int           gap;   // cycles since previous output beat, 0 = unchecked
  } exp_t;

  typedef struct {
    logic [NS-1:0] v;
    logic [NS-1:0] sop;
    logic [NS-1:0] rdy;
    logic          any;
    logic [1:0]    gnt;
    logic [7:0]    orph;
  } vec_t;

  sbeat_t        sq [NS][$];
  exp_t          sb [$];
  logic [NS-1:0] acc, shown;
  logic          rdy_cfg;
  int            n_assert = 0, n_fail = 0;
  int            cyc = 0, prev_cyc = 0, out_beats = 0;
  vec_t          tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present the head of each source queue on the bus.
  task automatic drive();
    sbeat_t b;
    for (int i = 0; i < NS; i++) begin
      if (sq[i].size() > 0) begin
        b = sq[i][0];
        shown[i] = 1'b1;
      end else begin
        b = '0;
        shown[i] = 1'b0;
      end
      src_valid[i]       = b.v;
      src_sop[i]         = b.sop;
      src_eop[i]         = b.eop;
      src_error[i]       = b.err;
      src_data[i*W +: W] = b.data;
    end
    out_ready = rdy_cfg;
  endtask

  // One clock: retire accepted/idle beats, drive, then sample mid-cycle.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NS; i++) begin
      if (sq[i].size() > 0 && shown[i] && (acc[i] || !sq[i][0].v))
        void'(sq[i].pop_front());
    end
    acc = '0;
    drive();
    @(negedge clk);
    acc = src_valid & src_ready;
    if (out_valid && out_ready) begin
      out_beats++;
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", out_src_id, out_data);
      end else begin
        e = sb.pop_front();
        chk("beat", {27'b0, out_sop, out_eop, out_error, out_src_id, out_data},
                    {27'b0, e.sop, e.eop, e.err, e.id, e.data});
        if (e.gap != 0) chk("beat_gap", 64'(cyc - prev_cyc), 64'(e.gap));
      end
      prev_cyc = cyc;
    end
  endtask

  task automatic push_beat(input int s, input logic sop, input logic eop, input logic [W-1:0] data,
                           input bit to_sb, input int gap);
    exp_t e;
    sq[s].push_back('{v: 1'b1, sop: sop, eop: eop, err: 1'b0, data: data});
    if (to_sb) begin
      e = '{sop: sop, eop: eop, err: 1'b0, id: 2'(s), data: data, gap: gap};
      sb.push_back(e);
    end
  endtask

  task automatic add_pkt(input int s, input int n, input int pk, input int first_gap);
    for (int b = 0; b < n; b++)
      push_beat(s, b == 0, b == n - 1, {8'(s), 8'(pk), 16'(b)}, 1'b1, (b == 0) ? first_gap : 1);
  endtask

  task automatic add_gap(input int s, input int n);
    for (int k = 0; k < n; k++) sq[s].push_back('0);
  endtask

  task automatic clear_bench();
    for (int i = 0; i < NS; i++) sq[i].delete();
    sb.delete();
    acc     = '0;
    shown   = '0;
    rdy_cfg = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int start = out_beats;
    int c = 0;
    while (out_beats - start < n && c < budget) begin
      step();
      c++;
    end
    chk({name, "_beats"}, 64'(out_beats - start), 64'(n));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    int left;
    left = 0;
    for (int i = 0; i < NS; i++) left += sq[i].size();
    while (left != 0 && c < budget) begin
      step();
      c++;
      left = 0;
      for (int i = 0; i < NS; i++) left += sq[i].size();
    end
    chk({name, "_drained"}, 64'(left), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    src_valid = '0; src_sop = '0; src_eop = '0; src_error = '0; src_data = '0;
    out_ready = 1'b1;
    rdy_cfg   = 1'b1;
    acc = '0; shown = '0;

    // valid, sop -> IDLE src_ready, grant expected, granted id, orphan count after one edge
    tbl[0] = '{v: 4'b0000, sop: 4'b0000, rdy: 4'b0000, any: 1'b0, gnt: 2'd0, orph: 8'd0};
    tbl[1] = '{v: 4'b0101, sop: 4'b0101, rdy: 4'b0000, any: 1'b1, gnt: 2'd0, orph: 8'd0};
    tbl[2] = '{v: 4'b1100, sop: 4'b1100, rdy: 4'b0000, any: 1'b1, gnt: 2'd2, orph: 8'd0};
    tbl[3] = '{v: 4'b1000, sop: 4'b1000, rdy: 4'b0000, any: 1'b1, gnt: 2'd3, orph: 8'd0};
    tbl[4] = '{v: 4'b1111, sop: 4'b0000, rdy: 4'b1111, any: 1'b0, gnt: 2'd0, orph: 8'd4};
    tbl[5] = '{v: 4'b0110, sop: 4'b0100, rdy: 4'b0010, any: 1'b1, gnt: 2'd2, orph: 8'd1};
    tbl[6] = '{v: 4'b0011, sop: 4'b1010, rdy: 4'b0001, any: 1'b1, gnt: 2'd1, orph: 8'd1};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_src_id", 64'(out_src_id), 64'd0);
    chk("rst_orphan", 64'(orphan_cnt), 64'd0);
    chk("rst_abort", 64'(abort_cnt), 64'd0);

    // Vector table: each row starts from reset
    for (int r = 0; r < 7; r++) begin
      @(posedge clk);
      #1 rst = 1'b1;
      src_valid = tbl[r].v; src_sop = tbl[r].sop; src_eop = '0; src_error = '0; src_data = '0;
      out_ready = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), 64'(src_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d_idle_valid", r), 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy_valid", r), 64'(out_valid), 64'(tbl[r].any));
      if (tbl[r].any) chk($sformatf("tbl%0d_gnt", r), 64'(out_src_id), 64'(tbl[r].gnt));
      chk($sformatf("tbl%0d_orphan", r), 64'(orphan_cnt), 64'(tbl[r].orph));
    end

    // 1: src0 and src2 sop together; src0 first, one bubble, then src2
    do_reset();
    add_pkt(0, 3, 0, 0);
    add_pkt(2, 2, 0, 2);
    wait_beats(5, 30, "t1");
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: four sources streaming 3-beat packets back to back
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        add_pkt(s, 3, p, (p == 0 && s == 0) ? 0 : 2);
    wait_beats(24, 60, "t2");
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: long downstream stall mid-packet never aborts
    do_reset();
    add_pkt(1, 4, 0, 0);
    sb[2].gap = 501;
    wait_beats(2, 20, "t3a");
    rdy_cfg = 1'b0;
    repeat (500) step();
    chk("t3_held_valid", 64'(out_valid), 64'd1);
    chk("t3_held_id", 64'(out_src_id), 64'd1);
    chk("t3_held_data", 64'(out_data), 64'h0100_0002);
    chk("t3_abort_stall", 64'(abort_cnt), 64'd0);
    rdy_cfg = 1'b1;
    wait_beats(2, 20, "t3b");
    chk("t3_abort_end", 64'(abort_cnt), 64'd0);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // 4: src3 starves after two beats -> abort beat, tail discarded as orphans
    do_reset();
    push_beat(3, 1'b1, 1'b0, 32'h0300_0000, 1'b1, 0);
    push_beat(3, 1'b0, 1'b0, 32'h0300_0001, 1'b1, 1);
    sb.push_back('{sop: 1'b0, eop: 1'b1, err: 1'b1, id: 2'd3, data: '0, gap: TMO + 1});
    add_gap(3, 300);
    push_beat(3, 1'b0, 1'b0, 32'h0300_0002, 1'b0, 0);
    push_beat(3, 1'b0, 1'b0, 32'h0300_0003, 1'b0, 0);
    push_beat(3, 1'b0, 1'b1, 32'h0300_0004, 1'b0, 0);
    wait_beats(3, 400, "t4");
    wait_drain(400, "t4");
    chk("t4_abort", 64'(abort_cnt), 64'd1);
    chk("t4_orphan", 64'(orphan_cnt), 64'd3);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 5: 300 orphan beats saturate the orphan counter
    do_reset();
    for (int k = 0; k < 300; k++) push_beat(1, 1'b0, 1'b0, 32'(k), 1'b0, 0);
    wait_drain(400, "t5");
    chk("t5_orphan_sat", 64'(orphan_cnt), 64'hFF);
    chk("t5_abort", 64'(abort_cnt), 64'd0);

    // 6: reset mid-packet, then src0 wins a tie against src1
    do_reset();
    add_pkt(0, 4, 0, 0);
    wait_beats(1, 20, "t6a");
    @(posedge clk);
    #1 rst = 1'b1;
    clear_bench();
    @(negedge clk);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_ready", 64'(src_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    add_pkt(0, 2, 1, 0);
    add_pkt(1, 2, 1, 2);
    wait_beats(4, 30, "t6b");
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
